spi_frame_sequencer: RTL and testbench

SPI_FRAME_SEQUENCER -- requirements
Module: spi_frame_sequencer

---
 rtl/spi_frame_pkg.sv | 27 ++
 rtl/motor_rr_select.sv | 46 ++++
 rtl/spi_frame_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_spi_frame_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_pkg.sv
// ---------------------------------------------------------------------------
// spi_frame_pkg
// Shared types and constants for the SPI frame sequencer: the FSM state
// enum, the start-of-frame word, the PWM sign-bit mask and the receive-word
// indices that carry motor readbacks.
// ---------------------------------------------------------------------------
package spi_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_ACK,
        ST_GAP,
        ST_DRAIN
    } state_t;

    localparam logic [15:0] SOF_WORD = 16'h8000;
    localparam logic [15:0] PWM_MASK = 16'h7FFF;

    // Receive-word positions of the readback fields within a frame
    localparam logic [4:0] POS_HI = 5'd5;
    localparam logic [4:0] POS_LO = 5'd6;
    localparam logic [4:0] VEL    = 5'd7;
    localparam logic [4:0] CUR    = 5'd8;
    localparam logic [4:0] DISP   = 5'd9;

endpackage

// File: rtl/motor_rr_select.sv
// ---------------------------------------------------------------------------
// motor_rr_select
// Round-robin motor pointer. Combinationally finds the first enabled motor
// after the current one (wrapping) and registers it when told to advance.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   i_advance      : load the next enabled motor into the pointer
//   i_motor_en     : per-motor enable mask
//   o_active       : registered pointer (resets to NUM_MOTORS-1 so the
//                    first frame lands on motor 0)
// ---------------------------------------------------------------------------
module motor_rr_select
    import spi_frame_pkg::*;
#(
    parameter int unsigned NUM_MOTORS = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  i_advance,
    input  logic [NUM_MOTORS-1:0] i_motor_en,
    output logic [3:0]            o_active
);

    logic [3:0] r_active;
    logic [3:0] w_next;

    // Scan from farthest to nearest so the nearest enabled motor wins;
    // k = NUM_MOTORS is the current motor itself (sole enabled motor case).
    always_comb begin
        w_next = r_active;
        for (int unsigned k = NUM_MOTORS; k >= 1; k--) begin
            if (1'(i_motor_en >> ((32'(r_active) + k) % NUM_MOTORS)))
                w_next = 4'((32'(r_active) + k) % NUM_MOTORS);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_active <= 4'(NUM_MOTORS - 1);
        else if (i_advance)
            r_active <= w_next;
    end

    assign o_active = r_active;

endmodule

// File: rtl/spi_frame_sequencer.sv
// ---------------------------------------------------------------------------
// spi_frame_sequencer
// Feeds fixed-length SPI frames to an SPI master, one frame per start
// request, round-robin over the enabled motor boards. Transmits a header,
// the motor's PWM reference and shared control flags, and captures the
// position/velocity/current/displacement readbacks returned in the frame.
// Optional feature macro: SPI_INTERWORD_DELAY_EN -- when defined, each loaded
// word is held DELAY_CYCLES clocks before wren is raised.
// Ports:
//   clock, reset_n           : clock, asynchronous active-low reset
//   start, motor_en          : frame request, round-robin enable mask
//   ss_n, di_req, write_ack  : SPI master handshake (write_ack rising edge)
//   data_read_valid/data_read: receive word, captured on valid falling edge
//   pwm_ref, ctrl_flags      : transmit payload sources
//   word, wren               : transmit word and its valid
//   ss_n_o                   : per-motor slave selects
//   active_motor, busy, frame_done : frame status
//   position, velocity, current, displacement : per-motor readbacks
// ---------------------------------------------------------------------------
module spi_frame_sequencer
    import spi_frame_pkg::*;
#(
    parameter int unsigned NUM_MOTORS   = 8,
    parameter int unsigned FRAME_WORDS  = 12,
    parameter int unsigned TX_WORDS     = 5,
    parameter int unsigned DELAY_CYCLES = 64
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [NUM_MOTORS-1:0]      motor_en,
    input  logic                       ss_n,
    input  logic                       di_req,
    input  logic                       write_ack,
    input  logic                       data_read_valid,
    input  logic [15:0]                data_read,
    input  logic [16*NUM_MOTORS-1:0]   pwm_ref,
    input  logic [31:0]                ctrl_flags,
    output logic [15:0]                word,
    output logic                       wren,
    output logic [NUM_MOTORS-1:0]      ss_n_o,
    output logic [3:0]                 active_motor,
    output logic                       busy,
    output logic                       frame_done,
    output logic [32*NUM_MOTORS-1:0]   position,
    output logic [16*NUM_MOTORS-1:0]   velocity,
    output logic [16*NUM_MOTORS-1:0]   current,
    output logic [16*NUM_MOTORS-1:0]   displacement
);

    if (NUM_MOTORS == 0 || NUM_MOTORS > 16 || FRAME_WORDS < 10 || FRAME_WORDS > 32 ||
        DELAY_CYCLES == 0 || DELAY_CYCLES > 255) begin : g_bad_params
        $error("spi_frame_sequencer: parameter out of range");
    end

    state_t      r_state;
    logic [15:0] r_word;
    logic        r_wren;
    logic        r_busy;
    logic        r_frame_done;
    logic        r_ack_q;
    logic        r_drv_q;
    logic [5:0]  r_tx_cnt;
    logic [4:0]  r_rx_cnt;
`ifdef SPI_INTERWORD_DELAY_EN
    logic [7:0]  r_dly_cnt;
`endif

    logic [3:0]  w_active;
    logic        w_advance;
    logic        w_ack_rise;
    logic        w_cap;
    logic        w_store;
    logic [15:0] w_pwm;
    logic [15:0] w_tx_word;

    assign w_advance  = (r_state == ST_IDLE) && start && ss_n && (|motor_en);
    assign w_ack_rise = write_ack && !r_ack_q;
    assign w_cap      = (r_state != ST_IDLE) && r_drv_q && !data_read_valid;
    assign w_store    = w_cap && (32'(r_rx_cnt) < FRAME_WORDS);
    assign w_pwm      = 16'(pwm_ref >> (16 * 32'(w_active)));

    motor_rr_select #(.NUM_MOTORS(NUM_MOTORS)) u_rr (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_advance  (w_advance),
        .i_motor_en (motor_en),
        .o_active   (w_active)
    );

    // Transmit word for the current tx index; payload only in the first TX_WORDS
    always_comb begin
        w_tx_word = 16'h0000;
        if (32'(r_tx_cnt) < TX_WORDS) begin
            case (r_tx_cnt)
                6'd0:    w_tx_word = SOF_WORD;
                6'd1:    w_tx_word = w_pwm & PWM_MASK;
                6'd2:    w_tx_word = ctrl_flags[31:16];
                6'd3:    w_tx_word = ctrl_flags[15:0];
                default: w_tx_word = 16'h0000;
            endcase
        end
    end

    // Frame FSM with registered outputs and rx/tx counters
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_word       <= 16'h0000;
            r_wren       <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_ack_q      <= 1'b0;
            r_drv_q      <= 1'b0;
            r_tx_cnt     <= 6'd0;
            r_rx_cnt     <= 5'd0;
`ifdef SPI_INTERWORD_DELAY_EN
            r_dly_cnt    <= 8'd0;
`endif
        end else begin
            r_frame_done <= 1'b0;
            r_ack_q      <= write_ack;
            r_drv_q      <= data_read_valid;
            if (w_cap && r_rx_cnt != 5'd31)
                r_rx_cnt <= r_rx_cnt + 5'd1;

            case (r_state)
                ST_IDLE: begin
                    if (w_advance) begin
                        r_state  <= ST_LOAD;
                        r_busy   <= 1'b1;
                        r_tx_cnt <= 6'd0;
                        r_rx_cnt <= 5'd0;
                    end
                end
                ST_LOAD: begin
                    r_word <= w_tx_word;
`ifdef SPI_INTERWORD_DELAY_EN
                    // First LOAD edge loads the word; wren follows DELAY_CYCLES edges later
                    if (r_dly_cnt == 8'(DELAY_CYCLES)) begin
                        r_dly_cnt <= 8'd0;
                        r_wren    <= 1'b1;
                        r_state   <= ST_WAIT_ACK;
                    end else begin
                        r_dly_cnt <= r_dly_cnt + 8'd1;
                    end
`else
                    r_wren  <= 1'b1;
                    r_state <= ST_WAIT_ACK;
`endif
                end
                ST_WAIT_ACK: begin
                    if (w_ack_rise) begin
                        r_wren   <= 1'b0;
                        r_tx_cnt <= r_tx_cnt + 6'd1;
                        r_state  <= (32'(r_tx_cnt) + 32'd1 < FRAME_WORDS) ? ST_GAP : ST_DRAIN;
                    end
                end
                ST_GAP: begin
                    if (di_req)
                        r_state <= ST_LOAD;
                end
                ST_DRAIN: begin
                    if (ss_n) begin
                        r_state      <= ST_IDLE;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign word         = r_word;
    assign wren         = r_wren;
    assign busy         = r_busy;
    assign frame_done   = r_frame_done;
    assign active_motor = w_active;

    // Per-motor slave select passthrough and readback storage
    for (genvar m = 0; m < NUM_MOTORS; m++) begin : g_motor
        logic [31:0] r_pos;
        logic [15:0] r_vel;
        logic [15:0] r_cur;
        logic [15:0] r_disp;
        logic        w_sel;

        assign w_sel     = w_store && (w_active == 4'(m));
        assign ss_n_o[m] = (r_busy && w_active == 4'(m)) ? ss_n : 1'b1;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_pos  <= 32'h0;
                r_vel  <= 16'h0;
                r_cur  <= 16'h0;
                r_disp <= 16'h0;
            end else if (w_sel) begin
                case (r_rx_cnt)
                    POS_HI:  r_pos[31:16] <= data_read;
                    POS_LO:  r_pos[15:0]  <= data_read;
                    VEL:     r_vel        <= data_read;
                    CUR:     r_cur        <= data_read;
                    DISP:    r_disp       <= data_read;
                    default: ;
                endcase
            end
        end

        assign position[32*m +: 32]     = r_pos;
        assign velocity[16*m +: 16]     = r_vel;
        assign current[16*m +: 16]      = r_cur;
        assign displacement[16*m +: 16] = r_disp;
    end

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_spi_frame_sequencer
// Directed bench for spi_frame_sequencer with a small SPI-master model and a
// scoreboard of expected transmit words. Follows SPI_INTERWORD_DELAY_EN.
// ---------------------------------------------------------------------------
module tb_spi_frame_sequencer;

    localparam int unsigned NM  = 4;
    localparam int unsigned FW  = 12;
    localparam int unsigned TXW = 5;
    localparam int unsigned DLY = 64;
`ifdef SPI_INTERWORD_DELAY_EN
    localparam int unsigned EXTRA = DLY;
`else
    localparam int unsigned EXTRA = 0;
`endif

    logic           clock = 1'b0;
    logic           reset_n;
    logic           start;
    logic [NM-1:0]  motor_en;
    logic           ss_n;
    logic           di_req;
    logic           write_ack;
    logic           data_read_valid;
    logic [15:0]    data_read;
    logic [16*NM-1:0] pwm_ref;
    logic [31:0]    ctrl_flags;
    logic [15:0]    word;
    logic           wren;
    logic [NM-1:0]  ss_n_o;
    logic [3:0]     active_motor;
    logic           busy;
    logic           frame_done;
    logic [32*NM-1:0] position;
    logic [16*NM-1:0] velocity;
    logic [16*NM-1:0] current;
    logic [16*NM-1:0] displacement;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] sb_q[$];
    logic [15:0] rx_words[FW];
    logic [31:0] m_pos[NM];
    logic [15:0] m_vel[NM];
    logic [15:0] m_cur[NM];
    logic [15:0] m_disp[NM];

    always #5 clock = ~clock;

    spi_frame_sequencer #(
        .NUM_MOTORS   (NM),
        .FRAME_WORDS  (FW),
        .TX_WORDS     (TXW),
        .DELAY_CYCLES (DLY)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .motor_en        (motor_en),
        .ss_n            (ss_n),
        .di_req          (di_req),
        .write_ack       (write_ack),
        .data_read_valid (data_read_valid),
        .data_read       (data_read),
        .pwm_ref         (pwm_ref),
        .ctrl_flags      (ctrl_flags),
        .word            (word),
        .wren            (wren),
        .ss_n_o          (ss_n_o),
        .active_motor    (active_motor),
        .busy            (busy),
        .frame_done      (frame_done),
        .position        (position),
        .velocity        (velocity),
        .current         (current),
        .displacement    (displacement)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_word(input int i, input int m);
        logic [15:0] p;
        p = 16'(pwm_ref >> (16 * m));
        if (i == 0) return 16'h8000;
        if (i == 1) return p & 16'h7FFF;
        if (i == 2) return ctrl_flags[31:16];
        if (i == 3) return ctrl_flags[15:0];
        return 16'h0000;
    endfunction

    task automatic clear_model();
        for (int m = 0; m < NM; m++) begin
            m_pos[m] = 32'h0; m_vel[m] = 16'h0; m_cur[m] = 16'h0; m_disp[m] = 16'h0;
        end
    endtask

    task automatic check_readbacks();
        for (int m = 0; m < NM; m++) begin
            chk($sformatf("position[%0d]", m), 64'(32'(position >> (32 * m))), 64'(m_pos[m]));
            chk($sformatf("velocity[%0d]", m), 64'(16'(velocity >> (16 * m))), 64'(m_vel[m]));
            chk($sformatf("current[%0d]", m), 64'(16'(current >> (16 * m))), 64'(m_cur[m]));
            chk($sformatf("displacement[%0d]", m), 64'(16'(displacement >> (16 * m))), 64'(m_disp[m]));
        end
    endtask

    // One frame from the SPI master side; n_acks < FW stops early for an abort
    task automatic run_frame(input int exp_m, input int n_acks, input bit poke);
        int n;
        logic [15:0] exp_w;
        for (int i = 0; i < FW; i++) sb_q.push_back(exp_word(i, exp_m));
        @(negedge clock); start = 1'b1; ss_n = 1'b1;
        @(negedge clock); start = 1'b0; ss_n = 1'b0;
        chk("busy_set", 64'(busy), 64'(1));
        chk("active_motor", 64'(active_motor), 64'(exp_m));
        for (int i = 0; i < n_acks; i++) begin
            n = 0;
            while (wren !== 1'b1 && n < 400) begin @(negedge clock); n++; end
            chk($sformatf("wren_latency[%0d]", i), 64'(n), 64'(1 + EXTRA));
            exp_w = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
            chk($sformatf("word[%0d]", i), 64'(word), 64'(exp_w));
            chk("ss_n_o_active", 64'(ss_n_o), 64'(4'hF & ~(4'b0001 << exp_m)));
            chk("frame_done_low", 64'(frame_done), 64'(0));
            write_ack = 1'b1; data_read_valid = 1'b1; data_read = rx_words[i];
            @(negedge clock); write_ack = 1'b0; data_read_valid = 1'b0;
            chk("wren_clear", 64'(wren), 64'(0));
            if (i < FW - 1) begin
                di_req = 1'b1;
                if (poke && i == 4) begin start = 1'b1; ss_n = 1'b1; end
                @(negedge clock); di_req = 1'b0; start = 1'b0; ss_n = 1'b0;
            end
        end
        if (n_acks == FW) begin
            @(negedge clock);
            chk("drain_busy", 64'(busy), 64'(1));
            ss_n = 1'b1;
            @(negedge clock);
            chk("frame_done_pulse", 64'(frame_done), 64'(1));
            chk("busy_drop", 64'(busy), 64'(0));
            chk("ss_n_o_idle", 64'(ss_n_o), 64'(4'hF));
            @(negedge clock);
            chk("frame_done_single", 64'(frame_done), 64'(0));
            chk("sb_empty", 64'(sb_q.size()), 64'(0));
            m_pos[exp_m]  = {rx_words[5], rx_words[6]};
            m_vel[exp_m]  = rx_words[7];
            m_cur[exp_m]  = rx_words[8];
            m_disp[exp_m] = rx_words[9];
            check_readbacks();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; ss_n = 1'b1; di_req = 1'b0;
        write_ack = 1'b0; data_read_valid = 1'b0; data_read = 16'h0;
        motor_en = 4'b0101;
        pwm_ref = {16'h1111, 16'h8123, 16'h2222, 16'hFFFF};
        ctrl_flags = 32'h0001_0002;
        clear_model();
        repeat (3) @(negedge clock);

        chk("rst_wren", 64'(wren), 64'(0));
        chk("rst_word", 64'(word), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_frame_done", 64'(frame_done), 64'(0));
        chk("rst_ss_n_o", 64'(ss_n_o), 64'(4'hF));
        chk("rst_active", 64'(active_motor), 64'(NM - 1));
        check_readbacks();
        reset_n = 1'b1;
        @(negedge clock);

        // Empty enable mask: start is ignored
        motor_en = 4'b0000; start = 1'b1;
        @(negedge clock); start = 1'b0;
        @(negedge clock);
        chk("no_en_busy", 64'(busy), 64'(0));
        chk("no_en_active", 64'(active_motor), 64'(NM - 1));
        motor_en = 4'b0101;

        rx_words = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0001, 16'h2345,
                     16'h0010, 16'h0020, 16'h0030, 16'hDEAD, 16'hBEEF};
        run_frame(0, FW, 1'b0);
        chk("pos_m0_literal", 64'(position[31:0]), 64'(32'h0001_2345));

        ctrl_flags = 32'hA5A5_5A5A;
        rx_words = '{16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'hFFFE, 16'h8001,
                     16'h7F00, 16'h00FF, 16'hC0DE, 16'h1234, 16'h5678};
        run_frame(2, FW, 1'b1);
        chk("poke_active_kept", 64'(active_motor), 64'(2));

        pwm_ref = {16'h1111, 16'h8123, 16'h2222, 16'h4321};
        rx_words = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0BAD, 16'hF00D,
                     16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505};
        run_frame(0, FW, 1'b0);

        // Abort mid-frame after three acknowledged words
        run_frame(2, 3, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("abort_wren", 64'(wren), 64'(0));
        chk("abort_ss_n_o", 64'(ss_n_o), 64'(4'hF));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_active", 64'(active_motor), 64'(NM - 1));
        @(negedge clock); reset_n = 1'b1;
        sb_q.delete();
        clear_model();
        check_readbacks();

        rx_words = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0001, 16'h2345,
                     16'h0010, 16'h0020, 16'h0030, 16'h0, 16'h0};
        run_frame(0, FW, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
